// File: rtl/add_pkg.sv
// add_pkg: shared constants, payload types and queue states for add_responder.
package add_pkg;
   localparam int ADD_W = 3;
   localparam int ADD_TAG_W = 8;
   typedef logic [ADD_W:0] add_sum_t;
   typedef logic [ADD_TAG_W-1:0] add_tag_t;
   typedef struct packed {
      add_sum_t sum;
      add_tag_t tag;
   } add_rsp_t;
   typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} q_state_e;
endpackage

// File: rtl/add_resp_fifo.sv
// add_resp_fifo: synchronous response queue; caller never pushes when full or pops when empty.
module add_resp_fifo import add_pkg::*; #(
   parameter int DEPTH = 4,
   parameter type T = add_rsp_t,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  T              din,
   output T              dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   T mem [DEPTH];
   logic [AW-1:0] wr, rd;
   assign dout = mem[rd];
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   always_ff @(posedge clk)
      if (push) mem[wr] <= din;
   // pointers wrap naturally since DEPTH is a power of two; count disambiguates full/empty
   always_ff @(posedge clk)
      if (!rst_n) begin
         wr <= '0;
         rd <= '0;
         count <= '0;
      end else begin
         if (push) wr <= wr + AW'(1);
         if (pop) rd <= rd + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
endmodule

// File: rtl/add_responder.sv
// add_responder: accepts (x, y), queues {x+y, tag}, returns over valid/ready.
// Define ADD_RESP_STATS_EN to add saturating stat_txn/stat_stall counters.
module add_responder import add_pkg::*; #(
   parameter int W = ADD_W,
   parameter int DEPTH = 4,
   parameter int TAG_W = ADD_TAG_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [W-1:0]     req_x,
   input  logic [W-1:0]     req_y,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [W:0]       rsp_sum,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             busy
`ifdef ADD_RESP_STATS_EN
   ,
   output logic [15:0]      stat_txn,
   output logic [15:0]      stat_stall
`endif
);
   localparam int CW = $clog2(DEPTH + 1);
   typedef struct packed {
      logic [W:0]       sum;
      logic [TAG_W-1:0] tag;
   } rsp_t;
   q_state_e state, state_nx;
   logic [TAG_W-1:0] next_tag;
   logic [CW-1:0] count;
   logic full, empty, push, pop;
   rsp_t head, entry;
   assign push = req_valid && req_ready && !full;
   assign pop = rsp_valid && rsp_ready;
   assign entry = '{sum: {1'b0, req_x} + {1'b0, req_y}, tag: next_tag};
   assign rsp_valid = state != EMPTY;
   assign busy = rsp_valid;
   assign rsp_sum = empty ? '0 : head.sum;
   assign rsp_tag = empty ? '0 : head.tag;
   add_resp_fifo #(.DEPTH(DEPTH), .T(rsp_t)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(entry),
      .dout(head), .full(full), .empty(empty), .count(count)
   );
   always_comb
      state_nx = (push && !pop) ? (count == CW'(DEPTH - 1) ? FULL : PARTIAL) :
                 (pop && !push) ? (count == CW'(1) ? EMPTY : PARTIAL) : state;
   // req_ready is registered from the next state, so a pop while full frees a slot one cycle later
   always_ff @(posedge clk)
      if (!rst_n) begin
         state <= EMPTY;
         req_ready <= 1'b0;
         next_tag <= '0;
      end else begin
         state <= state_nx;
         req_ready <= state_nx != FULL;
         if (push) next_tag <= next_tag + TAG_W'(1);
      end
`ifdef ADD_RESP_STATS_EN
   always_ff @(posedge clk)
      if (!rst_n) begin
         stat_txn <= '0;
         stat_stall <= '0;
      end else begin
         if (push && stat_txn != 16'hFFFF) stat_txn <= stat_txn + 16'd1;
         if (rsp_valid && !rsp_ready && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
      end
`endif
endmodule

// File: tb/tb_add_responder.sv
// tb_add_responder: directed self-checking bench for add_responder (W=3, DEPTH=4, TAG_W=8).
module tb_add_responder;
   logic clk = 0, rst_n = 0, req_valid = 0, rsp_ready = 0;
   logic [2:0] req_x = 0, req_y = 0;
   logic req_ready, rsp_valid, busy;
   logic [3:0] rsp_sum;
   logic [7:0] rsp_tag;
   int total = 0, bad = 0;
`ifdef ADD_RESP_STATS_EN
   logic [15:0] stat_txn, stat_stall;
`endif
   always #5 clk = ~clk;
   add_responder dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_sum(rsp_sum), .rsp_tag(rsp_tag), .busy(busy)
`ifdef ADD_RESP_STATS_EN
      , .stat_txn(stat_txn), .stat_stall(stat_stall)
`endif
   );
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst_n = 0; req_valid = 0; rsp_ready = 0;
      step();
      rst_n = 1;
      step();
   endtask
   task automatic send(input int x, input int y);
      bit done = 0;
      req_valid = 1; req_x = 3'(x); req_y = 3'(y);
      for (int k = 0; k < 20 && !done; k++) begin
         done = req_ready;
         step();
      end
      req_valid = 0;
      total++;
      if (!done) begin bad++; $display("FAIL send_accept got=timeout want=accepted x=%0d y=%0d", x, y); end
   endtask
   task automatic test_reset();
      rst_n = 0;
      step(); step();
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
      total++; if (rsp_sum !== 4'd0) begin bad++; $display("FAIL reset_rsp_sum got=%0d want=0", rsp_sum); end
      total++; if (rsp_tag !== 8'd0) begin bad++; $display("FAIL reset_rsp_tag got=%0d want=0", rsp_tag); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      rst_n = 1;
      step();
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", req_ready); end
   endtask
   task automatic test_basic();
      rsp_ready = 1;
      send(5, 5);
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", rsp_valid); end
      total++; if (rsp_sum !== 4'd10) begin bad++; $display("FAIL basic_sum0 got=%0d want=10", rsp_sum); end
      total++; if (rsp_tag !== 8'd0) begin bad++; $display("FAIL basic_tag0 got=%0d want=0", rsp_tag); end
      send(6, 6);
      total++; if (rsp_sum !== 4'd12) begin bad++; $display("FAIL basic_sum1 got=%0d want=12", rsp_sum); end
      total++; if (rsp_tag !== 8'd1) begin bad++; $display("FAIL basic_tag1 got=%0d want=1", rsp_tag); end
   endtask
   task automatic test_carry();
      send(7, 7);
      total++; if (rsp_sum !== 4'd14) begin bad++; $display("FAIL carry_sum got=%0d want=14", rsp_sum); end
      total++; if (rsp_tag !== 8'd2) begin bad++; $display("FAIL carry_tag got=%0d want=2", rsp_tag); end
      send(0, 0);
      total++; if (rsp_valid !== 1'b1 || rsp_sum !== 4'd0) begin bad++; $display("FAIL zero_sum got=%b/%0d want=1/0", rsp_valid, rsp_sum); end
      step();
      total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL drain_idle got=%b/%b want=0/0", rsp_valid, busy); end
      rsp_ready = 0;
   endtask
   task automatic test_full();
      do_reset();
      for (int i = 1; i <= 4; i++) send(i, i);
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", req_ready); end
      req_valid = 1; req_x = 5; req_y = 5;
      step(); step(); step();
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL full_hold_ready got=%b want=0", req_ready); end
      total++; if (rsp_sum !== 4'd2 || rsp_tag !== 8'd0) begin bad++; $display("FAIL full_head_stable got=%0d/%0d want=2/0", rsp_sum, rsp_tag); end
      rsp_ready = 1;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (rsp_valid !== 1'b1 || rsp_sum !== 4'(2 * (i + 1)) || rsp_tag !== 8'(i)) begin
            bad++; $display("FAIL full_drain[%0d] got=%b/%0d/%0d want=1/%0d/%0d", i, rsp_valid, rsp_sum, rsp_tag, 2 * (i + 1), i);
         end
         if (i == 0) begin
            total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL full_pop_ready got=%b want=0", req_ready); end
         end
         if (i == 1) begin
            total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL after_pop_ready got=%b want=1", req_ready); end
         end
         step();
         if (i == 1) req_valid = 0;
      end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL full_empty got=%b want=0", rsp_valid); end
      rsp_ready = 0;
   endtask
   task automatic test_back_to_back();
      int qs[$], qt[$];
      int x, y;
      do_reset();
      send(1, 2); send(2, 2);
      qs = '{3, 4}; qt = '{0, 1};
      rsp_ready = 1; req_valid = 1;
      for (int i = 0; i < 10; i++) begin
         x = i % 8; y = (i * 3) % 8;
         total++;
         if (rsp_valid !== 1'b1 || req_ready !== 1'b1 || rsp_sum !== 4'(qs[0]) || rsp_tag !== 8'(qt[0])) begin
            bad++; $display("FAIL b2b[%0d] got=%b/%b/%0d/%0d want=1/1/%0d/%0d", i, rsp_valid, req_ready, rsp_sum, rsp_tag, qs[0], qt[0]);
         end
         req_x = 3'(x); req_y = 3'(y);
         step();
         void'(qs.pop_front()); void'(qt.pop_front());
         qs.push_back(x + y); qt.push_back(2 + i);
      end
      req_valid = 0; rsp_ready = 0;
      total++; if (rsp_sum !== 4'(qs[0]) || rsp_tag !== 8'(qt[0])) begin bad++; $display("FAIL b2b_head got=%0d/%0d want=%0d/%0d", rsp_sum, rsp_tag, qs[0], qt[0]); end
      rsp_ready = 1;
      step();
      total++; if (rsp_valid !== 1'b1 || rsp_sum !== 4'(qs[1]) || rsp_tag !== 8'(qt[1])) begin bad++; $display("FAIL b2b_second got=%b/%0d/%0d want=1/%0d/%0d", rsp_valid, rsp_sum, rsp_tag, qs[1], qt[1]); end
      step();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_count2 got=%b want=0", rsp_valid); end
      rsp_ready = 0;
   endtask
   task automatic test_tag_wrap();
      do_reset();
      rsp_ready = 1;
      for (int i = 0; i < 257; i++) begin
         send(i % 8, 1);
         if (i == 255) begin
            total++; if (rsp_tag !== 8'd255) begin bad++; $display("FAIL tag_255 got=%0d want=255", rsp_tag); end
         end
         if (i == 256) begin
            total++; if (rsp_tag !== 8'd0 || rsp_sum !== 4'(256 % 8 + 1)) begin bad++; $display("FAIL tag_wrap got=%0d/%0d want=0/%0d", rsp_tag, rsp_sum, 256 % 8 + 1); end
         end
      end
      step();
      rsp_ready = 0;
   endtask
   task automatic test_reset_mid();
      do_reset();
      send(1, 1); send(2, 2); send(3, 3);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
      rst_n = 0;
      step();
      total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_sum !== 4'd0) begin bad++; $display("FAIL mid_reset got=%b/%b/%0d want=0/0/0", rsp_valid, busy, rsp_sum); end
      rst_n = 1;
      step();
      send(3, 4);
      total++; if (rsp_tag !== 8'd0 || rsp_sum !== 4'd7) begin bad++; $display("FAIL mid_next_tag got=%0d/%0d want=0/7", rsp_tag, rsp_sum); end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_full();
      test_back_to_back();
      test_tag_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
